// File: rtl/vga_sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_sram_arb_pkg
// Description : Shared types and constants for the VGA / draw SRAM arbiter.
//               Client identifiers, the read-return tag type and default
//               SRAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_sram_arb_pkg;

  // Default SRAM geometry (18-bit word address, 16-bit data)
  localparam int DEF_AW = 18;
  localparam int DEF_DW = 16;

  // Client identifiers carried in the read-return tag
  localparam logic CLI_DISP = 1'b0;
  localparam logic CLI_WR   = 1'b1;

  // One tag per issued SRAM command slot; valid marks a read in flight
  typedef struct packed {
    logic valid;
    logic client;
  } rd_tag_t;

  localparam rd_tag_t TAG_NONE = '{valid: 1'b0, client: CLI_DISP};

endpackage
`default_nettype wire

// File: rtl/vga_sram_arb_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vga_sram_arb_rd_pipe
// Description : READ_LAT+1 deep shift register of read-return tags. Stage 0
//               lines up with the registered SRAM command; the last stage
//               lines up with the cycle SRAM_RDATA is valid for that command.
//               Synchronous clear discards every read in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sram_arb_rd_pipe
  import vga_sram_arb_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t [READ_LAT:0] pipe_q;
  rd_tag_t [READ_LAT:0] pipe_d;

  // Shift the new tag in at stage 0, everything else moves one stage along
  always_comb begin
    pipe_d = {pipe_q[READ_LAT-1:0], i_tag};
  end

  // Tag storage; reset empties the pipe so no stale response can surface
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign o_tag = pipe_q[READ_LAT];

endmodule
`default_nettype wire

// File: rtl/vga_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_sram_arbiter
// Description : Shares one synchronous single-port pixel SRAM between the
//               display line-prefetch client and the draw client. Display
//               has priority during active video, draw during blanking.
//               Commands are registered onto the SRAM pins one cycle after
//               the grant; read data is steered back to the issuing client
//               through a tagged latency pipe (RVALID = GNT + READ_LAT + 2).
//               Optional: define VGA_SRAM_ARB_WR_GUARD_EN to force a draw
//               grant after WR_GUARD cycles of waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sram_arbiter
  import vga_sram_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int READ_LAT = 2,
  parameter int WR_GUARD = 8
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  input  logic          VGA_BLANK_N,
  // display fetch client
  input  logic          DISP_REQ,
  input  logic [AW-1:0] DISP_ADDR,
  output logic          DISP_GNT,
  output logic          DISP_RVALID,
  output logic [DW-1:0] DISP_RDATA,
  // draw client
  input  logic          WR_REQ,
  input  logic          WR_WE,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [DW-1:0] WR_WDATA,
  output logic          WR_GNT,
  output logic          WR_RVALID,
  output logic [DW-1:0] WR_RDATA,
  // SRAM pins
  output logic          SRAM_CE,
  output logic          SRAM_WE,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [DW-1:0] SRAM_WDATA,
  input  logic [DW-1:0] SRAM_RDATA
);

  logic w_force_wr;
  logic w_disp_win;
  logic w_wr_win;

  // --------------------------------------------------------------------------
  // Draw starvation guard
  // --------------------------------------------------------------------------
`ifdef VGA_SRAM_ARB_WR_GUARD_EN
  localparam int GW = $clog2(WR_GUARD + 1);

  logic [GW-1:0] guard_cnt_q;
  logic [GW-1:0] guard_cnt_d;

  // Count cycles a draw request has waited; any grant or idle cycle restarts it
  always_comb begin
    guard_cnt_d = guard_cnt_q;
    if (!WR_REQ || WR_GNT) begin
      guard_cnt_d = '0;
    end else if (guard_cnt_q != GW'(WR_GUARD)) begin
      guard_cnt_d = guard_cnt_q + 1'b1;
    end
  end

  // Guard counter register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      guard_cnt_q <= '0;
    end else begin
      guard_cnt_q <= guard_cnt_d;
    end
  end

  assign w_force_wr = (guard_cnt_q == GW'(WR_GUARD));
`else
  // Strict blank-based priority; WR_GUARD has no effect in this build and
  // the comparison below is always false for legal values.
  assign w_force_wr = (WR_GUARD < 0);
`endif

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------

  // Single winner per cycle: display wins in active video unless the guard
  // fires; draw wins during blanking; a lone requester always wins.
  always_comb begin
    w_disp_win = !RESET && DISP_REQ &&
                 (!WR_REQ || (VGA_BLANK_N && !w_force_wr));
    w_wr_win   = !RESET && WR_REQ && !w_disp_win;
  end

  assign DISP_GNT = w_disp_win;
  assign WR_GNT   = w_wr_win;

  // --------------------------------------------------------------------------
  // Command registers and read-return steering
  // --------------------------------------------------------------------------
  logic          sram_ce_q,     sram_ce_d;
  logic          sram_we_q,     sram_we_d;
  logic [AW-1:0] sram_addr_q,   sram_addr_d;
  logic [DW-1:0] sram_wdata_q,  sram_wdata_d;
  logic          disp_rvalid_q, disp_rvalid_d;
  logic [DW-1:0] disp_rdata_q,  disp_rdata_d;
  logic          wr_rvalid_q,   wr_rvalid_d;
  logic [DW-1:0] wr_rdata_q,    wr_rdata_d;

  rd_tag_t w_tag_in;
  rd_tag_t w_tag_out;

  // Tag every granted read with its client; writes and idle slots are empty
  always_comb begin
    w_tag_in        = TAG_NONE;
    w_tag_in.valid  = w_disp_win || (w_wr_win && !WR_WE);
    w_tag_in.client = w_wr_win ? CLI_WR : CLI_DISP;
  end

  vga_sram_arb_rd_pipe #(
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Next-state for the SRAM pins and the per-client read data registers
  always_comb begin
    sram_ce_d    = w_disp_win || w_wr_win;
    sram_we_d    = w_wr_win && WR_WE;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if (w_wr_win) begin
      sram_addr_d = WR_ADDR;
      if (WR_WE) begin
        sram_wdata_d = WR_WDATA;
      end
    end else if (w_disp_win) begin
      sram_addr_d = DISP_ADDR;
    end

    disp_rvalid_d = w_tag_out.valid && (w_tag_out.client == CLI_DISP);
    wr_rvalid_d   = w_tag_out.valid && (w_tag_out.client == CLI_WR);
    disp_rdata_d  = disp_rvalid_d ? SRAM_RDATA : disp_rdata_q;
    wr_rdata_d    = wr_rvalid_d   ? SRAM_RDATA : wr_rdata_q;
  end

  // Pin and return-data registers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sram_ce_q     <= 1'b0;
      sram_we_q     <= 1'b0;
      sram_addr_q   <= '0;
      sram_wdata_q  <= '0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
      wr_rvalid_q   <= 1'b0;
      wr_rdata_q    <= '0;
    end else begin
      sram_ce_q     <= sram_ce_d;
      sram_we_q     <= sram_we_d;
      sram_addr_q   <= sram_addr_d;
      sram_wdata_q  <= sram_wdata_d;
      disp_rvalid_q <= disp_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      wr_rvalid_q   <= wr_rvalid_d;
      wr_rdata_q    <= wr_rdata_d;
    end
  end

  assign SRAM_CE     = sram_ce_q;
  assign SRAM_WE     = sram_we_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_WDATA  = sram_wdata_q;
  assign DISP_RVALID = disp_rvalid_q;
  assign DISP_RDATA  = disp_rdata_q;
  assign WR_RVALID   = wr_rvalid_q;
  assign WR_RDATA    = wr_rdata_q;

endmodule
`default_nettype wire

// File: doc/vga_sram_arbiter.md
Name: vga_sram_arbiter

Overview:
- Shares one synchronous single-port pixel SRAM between two requesters.
  - Display fetch client: line prefetch feeding the VGA timing/pixel path.
  - Draw client: pixel writer / read-modify-write engine.
- Priority follows the VGA blanking window. Display wins during active video; draw wins during blanking.
- Return data is routed to the issuing client through a tagged read-latency pipeline.
- Sits between the 640x480 timing generator (supplies VGA_BLANK_N) and the external SRAM pins.

Parameters:
- AW, 18, SRAM address width.
- DW, 16, SRAM data width.
- READ_LAT, 2, cycles from SRAM command (registered pins) to valid SRAM_RDATA; range 1..7.
- WR_GUARD, 8, max cycles a pending draw request may wait before forced grant (optional feature only).

Ports:
- CLOCK_50  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- VGA_BLANK_N  in  1  high = active video interval, low = sync/porch.
- DISP_REQ  in  1  display request; held with DISP_ADDR until DISP_GNT.
- DISP_ADDR  in  AW  display read address.
- DISP_GNT  out  1  one-cycle accept pulse, same cycle as decision.
- DISP_RVALID  out  1  display read data valid.
- DISP_RDATA  out  DW  display read data.
- WR_REQ  in  1  draw request; held with WR_WE/WR_ADDR/WR_WDATA until WR_GNT.
- WR_WE  in  1  1 = write, 0 = read.
- WR_ADDR  in  AW  draw address.
- WR_WDATA  in  DW  draw write data.
- WR_GNT  out  1  one-cycle accept pulse.
- WR_RVALID  out  1  draw read data valid (never pulsed for writes).
- WR_RDATA  out  DW  draw read data.
- SRAM_CE  out  1  registered command strobe.
- SRAM_WE  out  1  registered write enable.
- SRAM_ADDR  out  AW  registered address.
- SRAM_WDATA  out  DW  registered write data.
- SRAM_RDATA  in  DW  SRAM read data, valid READ_LAT cycles after command.

Behaviour:
- Reset values: all GNT/RVALID, SRAM_CE and SRAM_WE are 0. SRAM_ADDR, SRAM_WDATA, RDATA outputs are 0. Tag pipeline is cleared. Guard counter is 0.
- Arbitration: combinational each cycle; at most one grant per cycle.
  - VGA_BLANK_N=1: DISP_REQ wins over WR_REQ.
  - VGA_BLANK_N=0: WR_REQ wins over DISP_REQ.
  - A single requester is always granted.
  - No requester: SRAM_CE=0 next cycle.
- Command path: a grant in cycle N drives the SRAM_* registers at cycle N+1 with the granted client's fields. SRAM_WE=1 only for a draw write.
- Tag pipeline (depth READ_LAT+1) records {valid, client} for each read command. SRAM_RDATA is registered into the matching client's RDATA.
- Read latency: RVALID pulses for one cycle at N+READ_LAT+2 after GNT in cycle N. Default is 4 cycles.
  - RDATA holds its last value when RVALID=0.
- Back-to-back reads from either client are accepted every cycle, so throughput is 1 cmd/cycle. Responses return in issue order.
- Read-after-write to the same address in consecutive grants: the read returns the new data. Command order is preserved and there is no reordering.
- VGA_BLANK_N toggling mid-stream changes priority from the next decision only. Already-issued commands are unaffected.
- RESET mid-operation: in-flight reads are discarded, so no RVALID follows reset. SRAM_CE drops to 0 on the next edge.

Optional Feature:
- Macro VGA_SRAM_ARB_WR_GUARD_EN.
- Defined:
  - A counter increments each cycle WR_REQ=1 and WR_GNT=0, and clears on WR_GNT or WR_REQ=0.
  - When it reaches WR_GUARD, the draw client wins that cycle regardless of VGA_BLANK_N. The counter then clears.
- Undefined: strict blank-based priority; the draw client can starve for a full active line.

Decomposition:
- Package vga_sram_arb_pkg holds:
  - client id constants CLI_DISP=0, CLI_WR=1;
  - the tag struct/type {valid, client};
  - default AW/DW values.
- One sub-module: vga_sram_arb_rd_pipe, a parameterised READ_LAT+1 shift register of tags with synchronous clear.

Test Plan:
1. RESET 3 cycles, no requests -> all outputs 0; SRAM_CE stays 0 for 10 cycles.
2. VGA_BLANK_N=1, DISP_REQ and WR_REQ(read) both asserted at cycle 5 -> DISP_GNT at 5; WR_GNT at 6 when DISP_REQ drops; DISP_RVALID at 9 with data at DISP_ADDR.
3. VGA_BLANK_N=0, both request -> WR_GNT first. Draw write 0xBEEF to 0x00100, then display read of 0x00100 next cycle -> DISP_RDATA=0xBEEF; no WR_RVALID.
4. Display streams 16 reads back-to-back, addresses 0..15 -> 16 consecutive DISP_GNT and 16 consecutive DISP_RVALID starting 4 cycles later, data in order.
5. Guard: macro defined, WR_GUARD=8, VGA_BLANK_N=1, DISP_REQ held, WR_REQ from cycle 0 -> WR_GNT at cycle 8 only. Macro undefined -> no WR_GNT for 100 cycles.
6. Two reads in flight, RESET asserted 1 cycle after second GNT -> no RVALID on either client afterwards; SRAM_CE=0 after the reset edge.
